// File: rtl/route_cmd_proc_pkg.sv
// route_pkg: shared types for the route command processor.
//   opcode_e : cmd[7:6] command opcodes
//   state_e  : command/ID service FSM states
package route_pkg;

    typedef enum logic [1:0] {
        OP_STOP = 2'b00,
        OP_GO   = 2'b01,
        OP_ENQ  = 2'b10,
        OP_NOP  = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        S_WAIT,
        S_CMD,
        S_IDCHK
    } state_e;

endpackage

// File: rtl/route_cmd_proc_dest_fifo.sv
// dest_fifo: synchronous FIFO of pending destination IDs.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push_i/pop_i      : enqueue din_i / dequeue head (ignored when full/empty)
//   flush_i           : empty the queue; wins over push/pop in the same cycle
//   dout_o            : current head entry
//   full_o/empty_o    : occupancy flags
//   count_o           : number of stored entries
module dest_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/route_cmd_proc.sv
// route_cmd_proc: decodes UART route commands into a current destination plus a
// queue of pending destinations, retires them on matching station IDs and drives
// go/prox_en and the piezo.
//   cmd_rdy/cmd/clr_cmd_rdy : command handshake ([7:6] opcode, [ID_W-1:0] ID)
//   ID_vld/ID/clr_ID_vld    : station ID handshake
//   Ok2Move                 : path clear; go = in_transit & Ok2Move
//   prox_en, in_transit     : destination active
//   dest_ID, q_cnt          : current destination, queued destination count
//   arrived, q_ovf          : 1-cycle pulses (match retired, ENQ dropped)
//   buzz, buzz_n            : complementary piezo drive while blocked
module route_cmd_proc #(
    parameter int ID_W     = 6,
    parameter int DEPTH    = 4,
    parameter int BUZZ_DIV = 12500
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_rdy,
    input  logic [7:0]               cmd,
    input  logic                     ID_vld,
    input  logic [7:0]               ID,
    input  logic                     Ok2Move,
    output logic                     clr_cmd_rdy,
    output logic                     clr_ID_vld,
    output logic                     go,
    output logic                     prox_en,
    output logic                     buzz,
    output logic                     buzz_n,
    output logic                     in_transit,
    output logic [ID_W-1:0]          dest_ID,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic                     arrived,
    output logic                     q_ovf
);

    import route_pkg::*;

    localparam int BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

    state_e          state_q, state_d;
    opcode_e         op;
    logic            in_transit_q, in_transit_d;
    logic [ID_W-1:0] dest_q, dest_d, fifo_dout;
    logic            arrived_q, arrived_d, q_ovf_q, q_ovf_d;
    logic            push, pop, flush, full, empty, match, en, last;
    logic [BW-1:0]   buzz_cnt_q;
    logic            buzz_q, buzz_n_q;
    logic            unused_cmd_bits;

    assign op              = opcode_e'(cmd[7:6]);
    assign unused_cmd_bits = ^(cmd[5:0] >> ID_W);
    // Upper ID bits must be zero so out-of-range station IDs never alias a destination.
    assign match           = in_transit_q && (ID[ID_W-1:0] == dest_q) && ((ID >> ID_W) == 8'd0);

    dest_fifo #(.W(ID_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (cmd[ID_W-1:0]),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (q_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT;
            in_transit_q <= 1'b0;
            dest_q       <= '0;
            arrived_q    <= 1'b0;
            q_ovf_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_transit_q <= in_transit_d;
            dest_q       <= dest_d;
            arrived_q    <= arrived_d;
            q_ovf_q      <= q_ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_transit_d = in_transit_q;
        dest_d       = dest_q;
        arrived_d    = 1'b0;
        q_ovf_d      = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        case (state_q)
            S_WAIT:  state_d = cmd_rdy ? S_CMD : (ID_vld ? S_IDCHK : S_WAIT);
            S_CMD: begin
                state_d = S_WAIT;
                // ENQ while idle starts a fresh route exactly like GO.
                if (op == OP_GO || (op == OP_ENQ && !in_transit_q)) begin
                    flush        = 1'b1;
                    dest_d       = cmd[ID_W-1:0];
                    in_transit_d = 1'b1;
                end else if (op == OP_ENQ) begin
                    push    = ~full;
                    q_ovf_d = full;
                end else if (op == OP_STOP) begin
                    flush        = 1'b1;
                    in_transit_d = 1'b0;
                end
            end
            S_IDCHK: begin
                state_d = S_WAIT;
                if (match) begin
                    arrived_d    = 1'b1;
                    pop          = ~empty;
                    dest_d       = empty ? dest_q : fifo_dout;
                    in_transit_d = ~empty;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign en   = in_transit_q & ~Ok2Move;
    assign last = buzz_cnt_q == BW'(BUZZ_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
            buzz_n_q   <= 1'b0;
        end else if (!en) begin
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
            buzz_n_q   <= 1'b0;
        end else begin
            buzz_cnt_q <= last ? '0 : buzz_cnt_q + 1'b1;
            buzz_q     <= buzz_q ^ last;
            buzz_n_q   <= ~(buzz_q ^ last);
        end
    end

    assign clr_cmd_rdy = state_q == S_CMD;
    assign clr_ID_vld  = state_q == S_IDCHK;
    assign in_transit  = in_transit_q;
    assign prox_en     = in_transit_q;
    assign go          = in_transit_q & Ok2Move;
    assign dest_ID     = dest_q;
    assign arrived     = arrived_q;
    assign q_ovf       = q_ovf_q;
    assign buzz        = buzz_q;
    assign buzz_n      = buzz_n_q;

endmodule
